// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
package bit_serializer_pkg;

    // Controller states; encoding fixed so traces read the same across builds.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register, selectable
// bit order, optional inter-word idle gap and a registered serial output.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0,
    parameter int IDLE_LVL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             w,
    output logic             w_valid,
    output logic             done
);

    localparam int              CW       = $clog2(WIDTH);
    localparam int              GW       = cntWidth(GAP);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0]   LAST_GAP = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic            IDLE_BIT = (IDLE_LVL != 0) ? 1'b1 : 1'b0;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [CW-1:0]      r_cnt;
    logic [GW-1:0]      r_gapCnt;
    logic [WIDTH-1:0]   r_hold;
    logic               r_holdFull;
    logic               r_w;
    logic               r_wValid;
    logic               r_done;

    state_t             w_stateNext;
    logic               w_accept;
    logic               w_lastBit;
    logic               w_lastGap;
    logic               w_load;
    logic               w_loadFromHold;
    logic               w_holdWrite;
    logic [WIDTH-1:0]   w_loadWord;
    logic [WIDTH-1:0]   w_shiftNext;
    logic [CW-1:0]      w_cntNext;
    logic [GW-1:0]      w_gapCntNext;
    logic               w_wNext;
    logic               w_wValidNext;
    logic               w_doneNext;

    // Ready comes straight from the holding flag, so it never depends on din_valid.
    assign din_ready  = !r_holdFull;
    assign w_accept   = din_valid && !r_holdFull;
    assign w_lastBit  = (r_cnt == LAST_BIT);
    assign w_lastGap  = (r_gapCnt == LAST_GAP);
    assign w_loadWord = w_loadFromHold ? r_hold : din;

    assign w       = r_w;
    assign w_valid = r_wValid;
    assign done    = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and load decisions: a word boundary pulls from the holding
    // register first, otherwise takes a word offered on the same edge.
    always_comb begin
        w_stateNext    = r_state;
        w_load         = 1'b0;
        w_loadFromHold = 1'b0;
        w_holdWrite    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_stateNext = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!w_lastBit) begin
                    w_holdWrite = w_accept;
                end else if (GAP > 0) begin
                    w_holdWrite = w_accept;
                    w_stateNext = S_GAP;
                end else if (r_holdFull) begin
                    w_load         = 1'b1;
                    w_loadFromHold = 1'b1;
                end else if (w_accept) begin
                    w_load = 1'b1;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            S_GAP: begin
                if (!w_lastGap) begin
                    w_holdWrite = w_accept;
                end else if (r_holdFull) begin
                    w_load         = 1'b1;
                    w_loadFromHold = 1'b1;
                    w_stateNext    = S_SHIFT;
                end else if (w_accept) begin
                    w_load      = 1'b1;
                    w_stateNext = S_SHIFT;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Datapath next values: load resets the bit counter, shifting walks it to WIDTH-1.
    always_comb begin
        w_shiftNext  = r_shift;
        w_cntNext    = r_cnt;
        w_gapCntNext = '0;
        if (w_load) begin
            w_shiftNext = w_loadWord;
            w_cntNext   = '0;
        end else if (r_state == S_SHIFT) begin
            w_shiftNext = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
            w_cntNext   = w_lastBit ? '0 : r_cnt + 1'b1;
        end
        if (r_state == S_GAP && !w_lastGap) begin
            w_gapCntNext = r_gapCnt + 1'b1;
        end
    end

    // Output decode: the bit that will be on the line after this edge.
    always_comb begin
        w_wValidNext = (w_stateNext == S_SHIFT);
        w_wNext      = IDLE_BIT;
        if (w_wValidNext) begin
            w_wNext = (MSB_FIRST != 0) ? w_shiftNext[WIDTH-1] : w_shiftNext[0];
        end
        w_doneNext = w_wValidNext && (w_cntNext == LAST_BIT);
    end

    // Shifter, counters and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_gapCnt <= '0;
            r_w      <= IDLE_BIT;
            r_wValid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_shift  <= w_shiftNext;
            r_cnt    <= w_cntNext;
            r_gapCnt <= w_gapCntNext;
            r_w      <= w_wNext;
            r_wValid <= w_wValidNext;
            r_done   <= w_doneNext;
        end
    end

    // Holding register: a new word always wins the slot, so a drain and a
    // fill on the same edge keep exactly one word queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold     <= '0;
            r_holdFull <= 1'b0;
        end else if (w_holdWrite) begin
            r_hold     <= din;
            r_holdFull <= 1'b1;
        end else if (w_loadFromHold) begin
            r_holdFull <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (default, GAP=2, LSB-first)
// share one stimulus stream; a timeline model predicts every output.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic [7:0] din;
    logic [2:0] wOut, wValidOut, doneOut, readyOut;

    int accA   [3][64];
    int startA [3][64];
    logic [7:0] wordA [3][64];
    int nW [3];
    int cyc;
    int nChecks;
    int nPass;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0), .IDLE_LVL(0)) dut0 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyOut[0]), .w(wOut[0]), .w_valid(wValidOut[0]), .done(doneOut[0]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(2), .IDLE_LVL(0)) dut1 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyOut[1]), .w(wOut[1]), .w_valid(wValidOut[1]), .done(doneOut[1]));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0), .IDLE_LVL(0)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyOut[2]), .w(wOut[2]), .w_valid(wValidOut[2]), .done(doneOut[2]));

    function automatic int gapOf(input int c);
        return (c == 1) ? 2 : 0;
    endfunction

    function automatic bit msbOf(input int c);
        return (c != 2);
    endfunction

    // A word is parked in the holding slot from its accept edge until its first bit.
    function automatic logic modelReady(input int c, input int n);
        logic r;
        r = 1'b1;
        for (int k = 0; k < nW[c]; k++) begin
            if (n >= accA[c][k] && n < startA[c][k]) r = 1'b0;
        end
        return r;
    endfunction

    // Expected {w, w_valid, done, din_ready} during the cycle after edge n.
    function automatic logic [3:0] modelOut(input int c, input int n);
        logic wb, vb, db;
        int pos;
        wb = 1'b0;
        vb = 1'b0;
        db = 1'b0;
        pos = 0;
        for (int k = 0; k < nW[c]; k++) begin
            if (n >= startA[c][k] && n < startA[c][k] + 8) begin
                pos = n - startA[c][k];
                wb  = msbOf(c) ? wordA[c][k][7-pos] : wordA[c][k][pos];
                vb  = 1'b1;
                db  = (pos == 7);
            end
        end
        return {wb, vb, db, modelReady(c, n)};
    endfunction

    task automatic modelClear();
        for (int c = 0; c < 3; c++) nW[c] = 0;
    endtask

    // Drive one cycle of stimulus, log accepts into the model, sample after the edge.
    task automatic stepCycle(input logic v, input logic [7:0] d);
        int s;
        din_valid = v;
        din       = d;
        if (rst && v) begin
            for (int c = 0; c < 3; c++) begin
                if (modelReady(c, cyc) && nW[c] < 64) begin
                    s = cyc + 1;
                    if (nW[c] > 0 && startA[c][nW[c]-1] + 8 + gapOf(c) > s)
                        s = startA[c][nW[c]-1] + 8 + gapOf(c);
                    accA[c][nW[c]]   = cyc + 1;
                    startA[c][nW[c]] = s;
                    wordA[c][nW[c]]  = d;
                    nW[c]++;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b0;
        din_valid = 1'b0;
        modelClear();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #3;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] gotV;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        for (int c = 0; c < 3; c++) begin
            gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
            nChecks++;
            if (gotV === 4'b0001) nPass++;
            else $display("[TB] FAIL reset_state cfg%0d got {w,vld,done,rdy}=%b expected=0001", c, gotV);
        end
        #2;
        rst = 1'b1;
        stepCycle(1'b1, 8'hC3);
        stepCycle(1'b0, 8'h00);
        stepCycle(1'b0, 8'h00);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
            nChecks++;
            if (gotV === 4'b0001) nPass++;
            else $display("[TB] FAIL async_reset cfg%0d got {w,vld,done,rdy}=%b expected=0001", c, gotV);
        end
        modelClear();
    endtask

    task automatic test_single_word();
        logic [3:0] gotV, expV;
        logic [7:0] seq0, seq2;
        int nb0, nb2;
        doReset();
        seq0 = '0; seq2 = '0; nb0 = 0; nb2 = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle(i == 0, (i == 0) ? 8'hB4 : 8'($urandom));
            for (int c = 0; c < 3; c++) begin
                expV = modelOut(c, cyc);
                gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
                nChecks++;
                if (gotV === expV) nPass++;
                else $display("[TB] FAIL single_word cfg%0d cyc%0d got {w,vld,done,rdy}=%b expected=%b", c, cyc, gotV, expV);
            end
            if (wValidOut[0] === 1'b1) begin seq0 = {seq0[6:0], wOut[0]}; nb0++; end
            if (wValidOut[2] === 1'b1) begin seq2 = {seq2[6:0], wOut[2]}; nb2++; end
        end
        nChecks++;
        if (seq0 === 8'hB4 && nb0 == 8) nPass++;
        else $display("[TB] FAIL msb_sequence got bits=%h count=%0d expected bits=b4 count=8", seq0, nb0);
        nChecks++;
        if (seq2 === 8'h2D && nb2 == 8) nPass++;
        else $display("[TB] FAIL lsb_of_b4 got bits=%h count=%0d expected bits=2d count=8", seq2, nb2);
    endtask

    task automatic test_back_to_back();
        logic [3:0] gotV, expV;
        int run0, maxRun0, notRdy0, first1, last1, vcnt1;
        doReset();
        run0 = 0; maxRun0 = 0; notRdy0 = 0; first1 = -1; last1 = -1; vcnt1 = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0)      stepCycle(1'b1, 8'hFF);
            else if (i == 2) stepCycle(1'b1, 8'h00);
            else             stepCycle(1'b0, 8'($urandom));
            for (int c = 0; c < 3; c++) begin
                expV = modelOut(c, cyc);
                gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
                nChecks++;
                if (gotV === expV) nPass++;
                else $display("[TB] FAIL back_to_back cfg%0d cyc%0d got {w,vld,done,rdy}=%b expected=%b", c, cyc, gotV, expV);
            end
            if (wValidOut[0] === 1'b1) run0++; else run0 = 0;
            if (run0 > maxRun0) maxRun0 = run0;
            if (readyOut[0] !== 1'b1) notRdy0++;
            if (wValidOut[1] === 1'b1) begin
                if (first1 < 0) first1 = i;
                last1 = i;
                vcnt1++;
            end
        end
        nChecks++;
        if (maxRun0 == 16) nPass++;
        else $display("[TB] FAIL contiguous_bits got run=%0d expected=16", maxRun0);
        nChecks++;
        if (notRdy0 == 6) nPass++;
        else $display("[TB] FAIL ready_low_cycles got %0d expected 6", notRdy0);
        nChecks++;
        if (vcnt1 == 16 && (last1 - first1 + 1 - vcnt1) == 2) nPass++;
        else $display("[TB] FAIL gap_bubbles got valid=%0d bubbles=%0d expected valid=16 bubbles=2", vcnt1, last1 - first1 + 1 - vcnt1);
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] gotV, expV;
        logic [7:0] seq0;
        int nb0;
        doReset();
        for (int i = 0; i < 4; i++) begin
            stepCycle(i < 2, (i == 0) ? 8'hAA : 8'h55);
            for (int c = 0; c < 3; c++) begin
                expV = modelOut(c, cyc);
                gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
                nChecks++;
                if (gotV === expV) nPass++;
                else $display("[TB] FAIL pre_reset cfg%0d cyc%0d got {w,vld,done,rdy}=%b expected=%b", c, cyc, gotV, expV);
            end
        end
        rst = 1'b0;
        din_valid = 1'b0;
        #1;
        modelClear();
        gotV = {wOut[0], wValidOut[0], doneOut[0], readyOut[0]};
        nChecks++;
        if (gotV === 4'b0001) nPass++;
        else $display("[TB] FAIL mid_word_reset got {w,vld,done,rdy}=%b expected=0001", gotV);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        nChecks++;
        if (doneOut === 3'b000 && wValidOut === 3'b000) nPass++;
        else $display("[TB] FAIL held_in_reset got done=%b vld=%b expected done=000 vld=000", doneOut, wValidOut);
        #2;
        rst = 1'b1;
        seq0 = '0; nb0 = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle(i == 0, (i == 0) ? 8'h81 : 8'($urandom));
            for (int c = 0; c < 3; c++) begin
                expV = modelOut(c, cyc);
                gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
                nChecks++;
                if (gotV === expV) nPass++;
                else $display("[TB] FAIL post_reset cfg%0d cyc%0d got {w,vld,done,rdy}=%b expected=%b", c, cyc, gotV, expV);
            end
            if (wValidOut[0] === 1'b1) begin seq0 = {seq0[6:0], wOut[0]}; nb0++; end
        end
        nChecks++;
        if (seq0 === 8'h81 && nb0 == 8) nPass++;
        else $display("[TB] FAIL restart_word got bits=%h count=%0d expected bits=81 count=8", seq0, nb0);
    endtask

    task automatic test_lsb_first();
        logic [3:0] gotV, expV;
        logic [7:0] seq2;
        int nb2;
        doReset();
        seq2 = '0; nb2 = 0;
        for (int i = 0; i < 11; i++) begin
            stepCycle(i == 0, (i == 0) ? 8'h0D : 8'($urandom));
            for (int c = 0; c < 3; c++) begin
                expV = modelOut(c, cyc);
                gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
                nChecks++;
                if (gotV === expV) nPass++;
                else $display("[TB] FAIL lsb_first cfg%0d cyc%0d got {w,vld,done,rdy}=%b expected=%b", c, cyc, gotV, expV);
            end
            if (wValidOut[2] === 1'b1) begin seq2 = {seq2[6:0], wOut[2]}; nb2++; end
        end
        nChecks++;
        if (seq2 === 8'hB0 && nb2 == 8) nPass++;
        else $display("[TB] FAIL lsb_sequence got bits=%h count=%0d expected bits=b0 count=8", seq2, nb2);
    endtask

    task automatic test_random();
        logic [3:0] gotV, expV;
        doReset();
        for (int i = 0; i < 300; i++) begin
            stepCycle($urandom_range(0, 3) != 0, 8'($urandom));
            for (int c = 0; c < 3; c++) begin
                expV = modelOut(c, cyc);
                gotV = {wOut[c], wValidOut[c], doneOut[c], readyOut[c]};
                nChecks++;
                if (gotV === expV) nPass++;
                else $display("[TB] FAIL random cfg%0d cyc%0d got {w,vld,done,rdy}=%b expected=%b", c, cyc, gotV, expV);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of tests");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        cyc       = 0;
        nChecks   = 0;
        nPass     = 0;
        modelClear();
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_mid_word();
        test_lsb_first();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
